sinc_avg_fifo: RTL and testbench
================================

// Module: sinc_avg_fifo
// PURPOSE
//   Post-decimation stage fed by the sinc2 decimator's 16-bit DATA output in the clk_fs domain.
//   Averages each non-overlapping block of 2**AVG_LOG2 accepted samples into one result.
//   Buffers results in a first-word-fall-through FIFO.
//   The consumer (host/UART packer) drains the FIFO through a valid/ready handshake.
// PARAMETERS
//   DW         16  sample and result width (unsigned)
//   AVG_LOG2   2   log2 of samples per averaging block (0 = pass-through, max 8)
//   DEPTH_LOG2 3   log2 of FIFO depth (default 8 entries)
// PORTS
//   clk_fs    in   1             sample clock; the only clock
//   rst       in   1             synchronous, active-high reset
//   en        in   1             capture enable; low discards any partial block
//   din       in   DW            decimated sample from the sinc2 DATA output
//   din_vld   in   1             sample strobe; tie high to take one sample per clk_fs
//   dout      out  DW            FIFO head; 0 when FIFO empty
//   dout_vld  out  1             FIFO not empty
//   dout_rdy  in   1             consumer ready; pop on dout_vld & dout_rdy
//   level     out  DEPTH_LOG2+1  number of stored entries, 0..2**DEPTH_LOG2
//   ovf       out  1             sticky: a result was dropped because the FIFO was full
//   ovf_clr   in   1             clears ovf; a set on the same edge takes precedence
// BEHAVIOUR
//   Reset:
//     - On any edge with rst=1: acc, cnt, rd/wr pointers, level and ovf are cleared.
//     - dout_vld=0, dout=0. FIFO contents are discarded. A partial block is lost.
//   Accept rule:
//     - A sample is accepted on an edge where en & din_vld.
//     - On accept: acc <= acc + din and cnt <= cnt + 1.
//     - acc is DW+AVG_LOG2 bits wide and cannot overflow.
//   Block end:
//     - On the accept where cnt == 2**AVG_LOG2-1, result = (acc + din) >> AVG_LOG2.
//     - Truncated, unsigned, DW bits.
//     - On that same edge: acc <= 0 and cnt <= 0, and the result is pushed.
//   Enable low:
//     - Any edge with en=0 sets acc <= 0 and cnt <= 0; the partial block is discarded.
//     - FIFO and handshake are unaffected.
//   Latency:
//     - The result is visible on dout/dout_vld the cycle after the last sample's edge, if the FIFO was empty.
//   FIFO (FWFT):
//     - dout always shows the oldest entry.
//     - The pop advances rd_ptr; the next entry appears the following cycle.
//     - Pointers wrap modulo 2**DEPTH_LOG2.
//     - level = pushes - pops and is updated on the same edge.
//   Full (level == 2**DEPTH_LOG2):
//     - With no pop on that edge, a push is dropped and ovf <= 1.
//     - Stored entries are never overwritten.
//   Full with simultaneous push and pop: both take effect, level is unchanged, no overflow.
//   Empty (level == 0):
//     - A pop cannot occur, since dout_vld=0.
//     - A push makes dout_vld=1 on the next cycle.
//   dout_rdy may toggle freely.
//   dout and dout_vld are stable while dout_vld=1 and dout_rdy=0.
//   AVG_LOG2=0: every accepted sample is pushed unchanged.
// TESTING
//   1. Reset: rst=1 for 2 cycles -> dout=0, dout_vld=0, level=0, ovf=0.
//   2. Average, default params:
//      - Stimulus: din=10,20,30,41, din_vld=1, en=1, dout_rdy=1.
//      - Expected: dout=25 (101>>2) with dout_vld=1 exactly one cycle after the 4th sample.
//   3. Max value: four samples of 16'hFFFF -> dout=16'hFFFF, with no wrap.
//   4. Enable abort:
//      - Stimulus: din=100 x2, then en=0 for 1 cycle, then din=4 x4.
//      - Expected: the single result is 4, and level=1.
//   5. Overflow:
//      - Stimulus: dout_rdy=0, push 9 blocks with values 1..9.
//      - Expected: level=8, ovf=1; drain returns 1..8 in order.
//      - Then pulse ovf_clr -> ovf=0.
//   6. Full with simultaneous push and pop:
//      - Stimulus: FIFO full; dout_rdy=1 on the edge the 9th result arrives.
//      - Expected: level stays 8, ovf=0, and the 9th result is read last.

Source files
------------

// File: rtl/sinc_avg_fifo.sv
// Block averager behind the sinc2 decimator: sums 2**AVG_LOG2 accepted samples, pushes the
// truncated mean into a first-word-fall-through FIFO drained by a valid/ready consumer.
module sinc_avg_fifo #(
  parameter int DW         = 16,
  parameter int AVG_LOG2   = 2,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk_fs,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DW-1:0]         din,
  input  logic                  din_vld,
  output logic [DW-1:0]         dout,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int AW    = DW + AVG_LOG2;
  localparam int CW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0]         CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [AW-1:0]         acc;
  logic [AW-1:0]         sum;
  logic [CW-1:0]         cnt;
  logic [DW-1:0]         result;
  logic                  last;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  wr_en;
  logic [DW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    sum      = acc + AW'(din);
    result   = DW'(sum >> AVG_LOG2);
    last     = (cnt == CNT_LAST);
    push     = en & din_vld & last;
    dout_vld = (level != '0);
    pop      = dout_vld & dout_rdy;
    full     = (level == LVL_FULL);
    // A full FIFO still takes the push when the same edge frees a slot.
    wr_en    = push & (~full | pop);
    dout     = dout_vld ? mem[rd_ptr] : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_fs) begin
    if (rst || !en) begin
      acc <= '0;
      cnt <= '0;
    end else if (din_vld) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_fs) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && full && !pop) ovf <= 1'b1;
      else if (ovf_clr)         ovf <= 1'b0;
    end
  end

  // NOTE: storage is left unreset; level gates dout, so stale words are never visible.
  always_ff @(posedge clk_fs) begin
    if (wr_en) mem[wr_ptr] <= result;
  end

endmodule

// File: tb/tb_sinc_avg_fifo.sv
// Directed bench for sinc_avg_fifo at default parameters: averaging, saturation-free max,
// enable abort, overflow and full-with-pop behaviour of the FWFT FIFO.
module tb_sinc_avg_fifo;

  logic        clk_fs = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] din;
  logic        din_vld;
  logic [15:0] dout;
  logic        dout_vld;
  logic        dout_rdy;
  logic [3:0]  level;
  logic        ovf;
  logic        ovf_clr;

  int checks   = 0;
  int failures = 0;

  sinc_avg_fifo dut (
    .clk_fs   (clk_fs),
    .rst      (rst),
    .en       (en),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .level    (level),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk_fs = ~clk_fs;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk_fs);
    #1;
  endtask

  task automatic push_block(input logic [15:0] val, input logic rdy_last);
    for (int i = 0; i < 4; i++) begin
      en      = 1'b1;
      din     = val;
      din_vld = 1'b1;
      if (i == 3) dout_rdy = rdy_last;
      step();
    end
    din_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; din = '0; din_vld = 1'b0; dout_rdy = 1'b0; ovf_clr = 1'b0;
    step();
    step();
    checks++;
    if (dout !== 16'd0 || dout_vld !== 1'b0 || level !== 4'd0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset: dout=%0h vld=%0b level=%0d ovf=%0b, required 0/0/0/0", dout, dout_vld, level, ovf);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_average();
    logic [15:0] samples [4];
    samples[0] = 16'd10; samples[1] = 16'd20; samples[2] = 16'd30; samples[3] = 16'd41;
    dout_rdy = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = samples[i]; din_vld = 1'b1;
      if (i == 3) begin
        checks++;
        if (dout_vld !== 1'b0) begin
          failures++;
          $display("FAIL avg_early: dout_vld=%0b before last sample, required 0", dout_vld);
        end
      end
      step();
    end
    din_vld = 1'b0;
    checks++;
    if (dout_vld !== 1'b1 || dout !== 16'd25) begin
      failures++;
      $display("FAIL avg_result: vld=%0b dout=%0d, required 1/25", dout_vld, dout);
    end
    step();
    checks++;
    if (dout_vld !== 1'b0 || level !== 4'd0 || dout !== 16'd0) begin
      failures++;
      $display("FAIL avg_popped: vld=%0b level=%0d dout=%0d, required 0/0/0", dout_vld, level, dout);
    end
  endtask

  task automatic test_max_value();
    dout_rdy = 1'b0;
    push_block(16'hFFFF, 1'b0);
    checks++;
    if (dout !== 16'hFFFF || level !== 4'd1) begin
      failures++;
      $display("FAIL max_value: dout=%0h level=%0d, required ffff/1", dout, level);
    end
    dout_rdy = 1'b1;
    step();
    dout_rdy = 1'b0;
  endtask

  task automatic test_enable_abort();
    dout_rdy = 1'b0;
    en = 1'b1; din = 16'd100; din_vld = 1'b1;
    step();
    step();
    en = 1'b0;
    step();
    push_block(16'd4, 1'b0);
    checks++;
    if (level !== 4'd1 || dout !== 16'd4) begin
      failures++;
      $display("FAIL enable_abort: level=%0d dout=%0d, required 1/4", level, dout);
    end
    dout_rdy = 1'b1;
    step();
    dout_rdy = 1'b0;
    checks++;
    if (level !== 4'd0) begin
      failures++;
      $display("FAIL abort_drain: level=%0d, required 0", level);
    end
  endtask

  task automatic test_overflow();
    dout_rdy = 1'b0;
    for (int k = 1; k <= 9; k++) push_block(16'(k), 1'b0);
    checks++;
    if (level !== 4'd8 || ovf !== 1'b1 || dout !== 16'd1) begin
      failures++;
      $display("FAIL overflow: level=%0d ovf=%0b dout=%0d, required 8/1/1", level, ovf, dout);
    end
    dout_rdy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (dout_vld !== 1'b1 || dout !== 16'(k)) begin
        failures++;
        $display("FAIL ovf_drain_%0d: vld=%0b dout=%0d, required 1/%0d", k, dout_vld, dout, k);
      end
      step();
    end
    dout_rdy = 1'b0;
    checks++;
    if (dout_vld !== 1'b0 || level !== 4'd0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_after_drain: vld=%0b level=%0d ovf=%0b, required 0/0/1", dout_vld, level, ovf);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr: ovf=%0b, required 0", ovf);
    end
  endtask

  task automatic test_full_push_pop();
    dout_rdy = 1'b0;
    for (int k = 1; k <= 8; k++) push_block(16'(k), 1'b0);
    checks++;
    if (level !== 4'd8) begin
      failures++;
      $display("FAIL full_fill: level=%0d, required 8", level);
    end
    push_block(16'd9, 1'b1);
    dout_rdy = 1'b0;
    checks++;
    if (level !== 4'd8 || ovf !== 1'b0 || dout !== 16'd2) begin
      failures++;
      $display("FAIL full_push_pop: level=%0d ovf=%0b dout=%0d, required 8/0/2", level, ovf, dout);
    end
    dout_rdy = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      checks++;
      if (dout_vld !== 1'b1 || dout !== 16'(k)) begin
        failures++;
        $display("FAIL full_drain_%0d: vld=%0b dout=%0d, required 1/%0d", k, dout_vld, dout, k);
      end
      step();
    end
    dout_rdy = 1'b0;
    checks++;
    if (dout_vld !== 1'b0 || level !== 4'd0) begin
      failures++;
      $display("FAIL full_empty: vld=%0b level=%0d, required 0/0", dout_vld, level);
    end
  endtask

  task automatic test_reset_flush();
    dout_rdy = 1'b0;
    push_block(16'd7, 1'b0);
    en = 1'b1; din = 16'd50; din_vld = 1'b1;
    step();
    din_vld = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (dout_vld !== 1'b0 || level !== 4'd0 || dout !== 16'd0) begin
      failures++;
      $display("FAIL reset_flush: vld=%0b level=%0d dout=%0d, required 0/0/0", dout_vld, level, dout);
    end
    // A partial sample before reset must not leak into the next block.
    push_block(16'd8, 1'b0);
    checks++;
    if (dout !== 16'd8 || level !== 4'd1) begin
      failures++;
      $display("FAIL reset_partial: dout=%0d level=%0d, required 8/1", dout, level);
    end
  endtask

  initial begin
    test_reset();
    test_average();
    test_max_value();
    test_enable_abort();
    test_overflow();
    test_full_push_pop();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
